// File: rtl/cnn_pkg.sv
// cnn_pkg: definitions shared by the CNN datapath blocks.
//   DATA_W           default feature-map pixel width
//   pixel_t          one feature-map pixel
//   pool_win_state_e window-former FSM state: FILL (even row), PAIR (odd row)
package cnn_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] pixel_t;

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } pool_win_state_e;

endpackage

// File: rtl/pool_row_buffer.sv
// pool_row_buffer: one feature-map row of pixels held in registers.
// It has one write port and two combinational read ports, so the two pixels
// of the upper window row are available in the same cycle.
//   clk                   clock
//   wr_en/wr_addr/wr_data write port (column index)
//   rd_addr_a/rd_data_a   read port A (left column of the window)
//   rd_addr_b/rd_data_b   read port B (right column of the window)
module pool_row_buffer #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] mem_q [IMG_W];
  logic [DATA_W-1:0] mem_d [IMG_W];

  // Entries are never reset: every entry is rewritten in the even row before
  // the following odd row reads it.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];

endmodule

// File: rtl/pool_window_buffer.sv
// pool_window_buffer: streaming 2x2 stride-2 window former.
// It takes pixels in row-major order, buffers the even row, and emits one
// 2x2 window for every odd-column pixel of each odd row.
//   clk, rst                     clock, synchronous active-high reset
//   pix_in/pix_valid/pix_ready   pixel input handshake
//   win_00..win_11               window (row,col) pixels
//   win_valid/win_ready          window output handshake
//   win_last                     marks the final window of a frame
module pool_window_buffer #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [DATA_W-1:0] win_00,
  output logic [DATA_W-1:0] win_01,
  output logic [DATA_W-1:0] win_10,
  output logic [DATA_W-1:0] win_11,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              win_last
);

  import cnn_pkg::*;

  localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_img_w
    $fatal(1, "pool_window_buffer: IMG_W must be even and at least 2");
  end
  if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_img_h
    $fatal(1, "pool_window_buffer: IMG_H must be even and at least 2");
  end

  pool_win_state_e   state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DATA_W-1:0] prev_pix_q, prev_pix_d;
  logic [DATA_W-1:0] win_00_q, win_00_d, win_01_q, win_01_d;
  logic [DATA_W-1:0] win_10_q, win_10_d, win_11_q, win_11_d;
  logic              win_valid_q, win_valid_d;
  logic              win_last_q, win_last_d;

  logic              accept;
  logic              col_last;
  logic              row_last;
  logic              buf_wr_en;
  logic              load_win;
  logic [COL_W-1:0]  rd_addr_left;
  logic [DATA_W-1:0] buf_left;
  logic [DATA_W-1:0] buf_right;

  // A held window stalls the input in every state.
  assign pix_ready = !win_valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign col_last  = (col_q == COL_LAST);
  assign row_last  = (row_q == ROW_LAST);

  // Windows are only formed on odd columns, so the left column is the current
  // column with its LSB cleared; this never underflows.
  assign rd_addr_left = {col_q[COL_W-1:1], 1'b0};

  pool_row_buffer #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .ADDR_W (COL_W)
  ) u_row_buffer (
    .clk       (clk),
    .wr_en     (buf_wr_en),
    .wr_addr   (col_q),
    .wr_data   (pix_in),
    .rd_addr_a (rd_addr_left),
    .rd_data_a (buf_left),
    .rd_addr_b (col_q),
    .rd_data_b (buf_right)
  );

  // Counters and FSM advance only on an accepted pixel. The output register
  // drops on consumption, but a same-cycle load wins and keeps it valid.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    prev_pix_d  = prev_pix_q;
    win_00_d    = win_00_q;
    win_01_d    = win_01_q;
    win_10_d    = win_10_q;
    win_11_d    = win_11_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    buf_wr_en   = 1'b0;
    load_win    = 1'b0;

    if (accept) begin
      if (col_last) begin
        col_d   = '0;
        row_d   = row_last ? '0 : row_q + 1'b1;
        state_d = (state_q == FILL) ? PAIR : FILL;
      end else begin
        col_d = col_q + 1'b1;
      end

      case (state_q)
        FILL: buf_wr_en = 1'b1;
        PAIR: begin
          if (col_q[0]) begin
            load_win = 1'b1;
          end else begin
            prev_pix_d = pix_in;
          end
        end
        default: ;
      endcase
    end

    if (win_valid_q && win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end

    if (load_win) begin
      win_00_d    = buf_left;
      win_01_d    = buf_right;
      win_10_d    = prev_pix_q;
      win_11_d    = pix_in;
      win_valid_d = 1'b1;
      win_last_d  = row_last && col_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      col_q       <= '0;
      row_q       <= '0;
      prev_pix_q  <= '0;
      win_00_q    <= '0;
      win_01_q    <= '0;
      win_10_q    <= '0;
      win_11_q    <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      prev_pix_q  <= prev_pix_d;
      win_00_q    <= win_00_d;
      win_01_q    <= win_01_d;
      win_10_q    <= win_10_d;
      win_11_q    <= win_11_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

  assign win_00    = win_00_q;
  assign win_01    = win_01_q;
  assign win_10    = win_10_q;
  assign win_11    = win_11_q;
  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;

endmodule

// File: tb/tb_pool_window_buffer.sv
// tb_pool_window_buffer: directed bench for pool_window_buffer on a 4x4 frame.
// A per-cycle vector table covers the basic frame; hand-written streams cover
// backpressure, input gaps, back-to-back frames, mid-frame reset and a pooled
// average of a constant frame.
module tb_pool_window_buffer;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [DW-1:0] win_00, win_01, win_10, win_11;
  logic          win_valid;
  logic          win_ready = 1'b1;
  logic          win_last;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic          v;
    logic [DW-1:0] pix;
    logic          rdy;
    logic          e_pr;
    logic          e_wv;
    logic [DW-1:0] e00, e01, e10, e11;
    logic          e_last;
  } vec_t;

  vec_t vecs[17];

  int             pix_vals[64];
  logic [127:0]   got_q[$];
  logic [127:0]   exp_q[$];
  logic           held_valid = 1'b0;
  logic [127:0]   held_win = '0;

  pool_window_buffer #(
    .DATA_W (DW),
    .IMG_W  (4),
    .IMG_H  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .win_00    (win_00),
    .win_01    (win_01),
    .win_10    (win_10),
    .win_11    (win_11),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_last  (win_last)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] packWin(input logic l, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic [DW-1:0] c,
                                           input logic [DW-1:0] d);
    return {63'd0, l, a, b, c, d};
  endfunction

  task automatic applyStimulus(input logic v, input logic [DW-1:0] p, input logic r);
    pix_valid = v;
    pix_in    = p;
    win_ready = r;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setVec(input int i, input logic v, input int p, input logic wv,
                        input int a, input int b, input int c, input int d, input logic l);
    vecs[i].v      = v;
    vecs[i].pix    = DW'(p);
    vecs[i].rdy    = 1'b1;
    vecs[i].e_pr   = 1'b1;
    vecs[i].e_wv   = wv;
    vecs[i].e00    = DW'(a);
    vecs[i].e01    = DW'(b);
    vecs[i].e10    = DW'(c);
    vecs[i].e11    = DW'(d);
    vecs[i].e_last = l;
  endtask

  task automatic pushExpFrame(input int b);
    exp_q.push_back(packWin(1'b0, DW'(b+1),  DW'(b+2),  DW'(b+5),  DW'(b+6)));
    exp_q.push_back(packWin(1'b0, DW'(b+3),  DW'(b+4),  DW'(b+7),  DW'(b+8)));
    exp_q.push_back(packWin(1'b0, DW'(b+9),  DW'(b+10), DW'(b+13), DW'(b+14)));
    exp_q.push_back(packWin(1'b1, DW'(b+11), DW'(b+12), DW'(b+15), DW'(b+16)));
  endtask

  // One cycle: drive at the falling edge, then sample, record consumed
  // windows and check that a stalled window stays put.
  task automatic sampleCycle();
    logic [127:0] cur;
    #1;
    cur = {62'd0, win_valid, win_last, win_00, win_01, win_10, win_11};
    if (win_valid && !win_ready) begin
      checkOutput("stall_pix_ready", {127'd0, pix_ready}, 128'd0);
    end
    if (held_valid) begin
      checkOutput("stall_hold", cur, held_win);
    end
    if (win_valid && win_ready) begin
      got_q.push_back(packWin(win_last, win_00, win_01, win_10, win_11));
    end
    held_valid = win_valid && !win_ready;
    held_win   = cur;
  endtask

  task automatic runStream(input int n, input bit toggle, input bit stall, input bit drain);
    int  idx = 0;
    int  budget = 0;
    int  stall_left = stall ? 3 : 0;
    bit  tog = 1'b1;
    logic v, r;
    while (idx < n && budget < 500) begin
      @(negedge clk);
      r = 1'b1;
      if (stall_left > 0 && win_valid) begin
        r = 1'b0;
        stall_left--;
      end
      v = toggle ? tog : 1'b1;
      tog = ~tog;
      applyStimulus(v, DW'(pix_vals[idx]), r);
      sampleCycle();
      if (v && pix_ready) idx++;
      budget++;
    end
    if (budget >= 500) begin
      checkOutput("stream_timeout", 128'(idx), 128'(n));
    end
    if (drain) begin
      repeat (4) begin
        @(negedge clk);
        applyStimulus(1'b0, '0, 1'b1);
        sampleCycle();
      end
    end
  endtask

  task automatic compareWindows(input string name);
    int n;
    checkOutput({name, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_win%0d", name, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // Basic frame 1..16 with the pooler always ready: each window is visible
    // the cycle after its win_11 pixel, and cleared the cycle after that.
    for (int k = 0; k < 16; k++) setVec(k, 1'b1, k + 1, 1'b0, 0, 0, 0, 0, 1'b0);
    setVec(16, 1'b0, 0, 1'b0, 0, 0, 0, 0, 1'b0);
    setVec(6,  1'b1, 7,  1'b1, 1,  2,  5,  6,  1'b0);
    setVec(8,  1'b1, 9,  1'b1, 3,  4,  7,  8,  1'b0);
    setVec(14, 1'b1, 15, 1'b1, 9,  10, 13, 14, 1'b0);
    setVec(16, 1'b0, 0,  1'b1, 11, 12, 15, 16, 1'b1);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_win", {62'd0, win_valid, win_last, win_00, win_01, win_10, win_11}, 128'd0);
    checkOutput("reset_pix_ready", {127'd0, pix_ready}, 128'd1);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].v, vecs[i].pix, vecs[i].rdy);
      #1;
      checkOutput($sformatf("vec%0d_pix_ready", i), {127'd0, pix_ready}, {127'd0, vecs[i].e_pr});
      checkOutput($sformatf("vec%0d_win_valid", i), {127'd0, win_valid}, {127'd0, vecs[i].e_wv});
      if (vecs[i].e_wv) begin
        checkOutput($sformatf("vec%0d_window", i),
                    packWin(win_last, win_00, win_01, win_10, win_11),
                    packWin(vecs[i].e_last, vecs[i].e00, vecs[i].e01, vecs[i].e10, vecs[i].e11));
      end
    end

    // Backpressure after the first window.
    for (int k = 0; k < 16; k++) pix_vals[k] = k + 1;
    runStream(16, 1'b0, 1'b1, 1'b1);
    pushExpFrame(0);
    compareWindows("stall");

    // pix_valid toggling every cycle.
    runStream(16, 1'b1, 1'b0, 1'b1);
    pushExpFrame(0);
    compareWindows("gaps");

    // Two frames with no gap between them.
    for (int k = 0; k < 16; k++) pix_vals[16 + k] = 101 + k;
    runStream(32, 1'b0, 1'b0, 1'b1);
    pushExpFrame(0);
    pushExpFrame(100);
    compareWindows("b2b");

    // Reset after 10 pixels of a frame, then a clean frame.
    for (int k = 0; k < 16; k++) pix_vals[k] = 200 + k;
    runStream(10, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    held_valid = 1'b0;
    #1;
    checkOutput("midrst_win_valid", {127'd0, win_valid}, 128'd0);
    checkOutput("midrst_pix_ready", {127'd0, pix_ready}, 128'd1);
    got_q.delete();
    for (int k = 0; k < 16; k++) pix_vals[k] = k + 1;
    runStream(16, 1'b0, 1'b0, 1'b1);
    pushExpFrame(0);
    compareWindows("midrst");

    // Constant frame through a 2x2 average: every result must be 4.
    for (int k = 0; k < 16; k++) pix_vals[k] = 4;
    runStream(16, 1'b0, 1'b0, 1'b1);
    checkOutput("pool_count", 128'(got_q.size()), 128'd4);
    foreach (got_q[i]) begin
      int sum;
      sum = int'(got_q[i][63:48]) + int'(got_q[i][47:32]) + int'(got_q[i][31:16]) + int'(got_q[i][15:0]);
      checkOutput($sformatf("pool_avg%0d", i), 128'(sum / 4), 128'd4);
    end
    got_q.delete();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
